// File: rtl/multi_user_free_queue_pkg.sv
// Shared definitions for the free-pointer queue of the shared-memory switch core.
// Sizes and the controller state encoding live here so every file agrees on them.
package multi_user_free_queue_pkg;

    localparam int FQ_DEPTH = 512;
    localparam int FQ_PTR_W = 10;
    localparam int FQ_CNT_W = 10;

    // INIT loads every cell pointer once after reset; RUN serves the users.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } fq_state_t;

endpackage : multi_user_free_queue_pkg

// File: rtl/multi_user_free_queue_fq_ptr_ram.sv
// Pointer storage for the free queue: DEPTH x PTR_W array with one synchronous
// write port and one asynchronous read port (the read port feeds the show-ahead head).
module fq_ptr_ram #(
    parameter int DEPTH = 512,
    parameter int PTR_W = 10,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [PTR_W-1:0] i_wdata,
    input  logic [IDX_W-1:0] i_raddr,
    output logic [PTR_W-1:0] o_rdata
);

    logic [PTR_W-1:0] r_mem [DEPTH];

    // Storage carries no reset: contents are only meaningful once written by INIT or a push.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : fq_ptr_ram

// File: rtl/multi_user_free_queue.sv
// Free-pointer queue: after reset it fills itself with every cell index, then
// hands out pointers in FIFO order (pop) and takes back freed ones (push).
module multi_user_free_queue
    import multi_user_free_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int PTR_W = FQ_PTR_W,
    parameter int CNT_W = FQ_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      ptr_din,
    input  logic             FQ_wr,
    input  logic             FQ_rd,
    output logic [PTR_W-1:0] ptr_dout_s,
    output logic             ptr_fifo_empty,
    output logic             FQ_act,
    output logic [CNT_W-1:0] FQ_count
);

    localparam int IDX_W = $clog2(DEPTH);

    fq_state_t        r_state;
    fq_state_t        w_nextState;
    logic [IDX_W-1:0] r_head;
    logic [IDX_W-1:0] r_tail;
    logic [IDX_W-1:0] r_initCnt;
    logic [CNT_W-1:0] r_count;

    logic             w_inInit;
    logic             w_initLast;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push;
    logic             w_ramWe;
    logic [IDX_W-1:0] w_ramWaddr;
    logic [PTR_W-1:0] w_ramWdata;
    logic [PTR_W-1:0] w_ramRdata;
    logic             w_unusedDin;

    // Circular index advance; written generically so a non power-of-two DEPTH also wraps.
    function automatic logic [IDX_W-1:0] nextIdx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(DEPTH - 1)) ? '0 : idx + 1'b1;
    endfunction

    assign w_unusedDin = &{1'b0, ptr_din[15:PTR_W]};

    assign w_inInit   = (r_state == ST_INIT);
    assign w_initLast = (r_initCnt == IDX_W'(DEPTH - 1));
    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_empty    = (r_count == '0);

    // Users are locked out during INIT; a push into a full queue only lands when a pop frees the slot.
    assign w_pop  = !w_inInit && FQ_rd && !w_empty;
    assign w_push = !w_inInit && FQ_wr && (!w_full || w_pop);

    // The single write port is shared: INIT loads k into entry k, RUN writes the returned pointer.
    assign w_ramWe    = !rst && (w_inInit || w_push);
    assign w_ramWaddr = w_inInit ? r_initCnt : r_tail;
    assign w_ramWdata = w_inInit ? PTR_W'(r_initCnt) : ptr_din[PTR_W-1:0];

    fq_ptr_ram #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .IDX_W (IDX_W)
    ) u_ptrRam (
        .i_clk   (clk),
        .i_we    (w_ramWe),
        .i_waddr (w_ramWaddr),
        .i_wdata (w_ramWdata),
        .i_raddr (r_head),
        .o_rdata (w_ramRdata)
    );

    // Controller state register; reset always restarts the self-initialisation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Leave INIT on the cycle the last cell pointer is written; RUN holds until reset.
    always_comb begin
        w_nextState = r_state;
        if (r_state == ST_INIT && w_initLast) begin
            w_nextState = ST_RUN;
        end
    end

    // Indices and occupancy: INIT appends one pointer per cycle, RUN applies push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_initCnt <= '0;
        end else if (w_inInit) begin
            r_tail    <= nextIdx(r_tail);
            r_count   <= r_count + 1'b1;
            r_initCnt <= nextIdx(r_initCnt);
        end else begin
            if (w_pop) begin
                r_head <= nextIdx(r_head);
            end
            if (w_push) begin
                r_tail <= nextIdx(r_tail);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign FQ_count       = r_count;
    assign ptr_fifo_empty = w_empty;
    assign FQ_act         = (r_state == ST_RUN);
    assign ptr_dout_s     = w_empty ? '0 : w_ramRdata;

endmodule : multi_user_free_queue

// File: tb/tb_multi_user_free_queue.sv
// Directed bench for the free-pointer queue: init timing, pops, pushes at the
// full/empty boundaries, simultaneous push/pop, wrap-around order and resets.
module tb_multi_user_free_queue;

    logic        clk;
    logic        rst;
    logic [15:0] ptrDin;
    logic        fqWr;
    logic        fqRd;
    logic [9:0]  ptrDoutS;
    logic        ptrFifoEmpty;
    logic        fqAct;
    logic [9:0]  fqCount;

    int errors;
    int checks;

    multi_user_free_queue dut (
        .clk            (clk),
        .rst            (rst),
        .ptr_din        (ptrDin),
        .FQ_wr          (fqWr),
        .FQ_rd          (fqRd),
        .ptr_dout_s     (ptrDoutS),
        .ptr_fifo_empty (ptrFifoEmpty),
        .FQ_act         (fqAct),
        .FQ_count       (fqCount)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Step one clock and land 1 ns after the edge, where outputs are sampled and inputs changed.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int actEarly;
        $display("[TB] test_reset");
        rst = 1'b1; fqWr = 1'b0; fqRd = 1'b0; ptrDin = '0;
        tick(); tick();
        checks++;
        if (fqCount !== 10'd0 || ptrFifoEmpty !== 1'b1 || fqAct !== 1'b0 || ptrDoutS !== 10'd0) begin
            errors++;
            $display("[TB] FAIL reset_values: count=%0d empty=%0b act=%0b dout=%0d, want 0/1/0/0",
                     fqCount, ptrFifoEmpty, fqAct, ptrDoutS);
        end
        rst = 1'b0;
        fqWr = 1'b1; fqRd = 1'b1; ptrDin = 16'h03FF;
        actEarly = 0;
        for (int n = 1; n <= 512; n++) begin
            tick();
            if (n < 512 && fqAct !== 1'b0) actEarly++;
            if (n == 100) begin
                checks++;
                if (fqCount !== 10'd100) begin
                    errors++;
                    $display("[TB] FAIL init_count100: got %0d want 100", fqCount);
                end
            end
        end
        fqWr = 1'b0; fqRd = 1'b0;
        checks++;
        if (actEarly != 0) begin
            errors++;
            $display("[TB] FAIL init_act_early: act high on %0d cycles, want 0", actEarly);
        end
        checks++;
        if (fqAct !== 1'b1 || fqCount !== 10'd512 || ptrFifoEmpty !== 1'b0 || ptrDoutS !== 10'd0) begin
            errors++;
            $display("[TB] FAIL init_done: act=%0b count=%0d empty=%0b dout=%0d, want 1/512/0/0",
                     fqAct, fqCount, ptrFifoEmpty, ptrDoutS);
        end
    endtask

    task automatic test_push_full();
        $display("[TB] test_push_full");
        ptrDin = 16'hFC07; fqWr = 1'b1;
        tick();
        fqWr = 1'b0;
        tick();
        checks++;
        if (fqCount !== 10'd512 || ptrDoutS !== 10'd0) begin
            errors++;
            $display("[TB] FAIL push_full: count=%0d dout=%0d, want 512/0", fqCount, ptrDoutS);
        end
    endtask

    task automatic test_pop_all();
        int headErr;
        $display("[TB] test_pop_all");
        headErr = 0;
        fqRd = 1'b1;
        for (int i = 0; i < 512; i++) begin
            if (ptrDoutS !== 10'(i)) begin
                headErr++;
                if (headErr <= 4) $display("[TB] FAIL pop_head[%0d]: got %0d want %0d", i, ptrDoutS, i);
            end
            tick();
        end
        checks++;
        if (headErr != 0) begin
            errors++;
            $display("[TB] FAIL pop_all_order: %0d wrong heads, want 0", headErr);
        end
        checks++;
        if (ptrFifoEmpty !== 1'b1 || fqCount !== 10'd0 || ptrDoutS !== 10'd0) begin
            errors++;
            $display("[TB] FAIL pop_all_empty: empty=%0b count=%0d dout=%0d, want 1/0/0",
                     ptrFifoEmpty, fqCount, ptrDoutS);
        end
        tick(); tick(); tick();
        fqRd = 1'b0;
        checks++;
        if (ptrFifoEmpty !== 1'b1 || fqCount !== 10'd0) begin
            errors++;
            $display("[TB] FAIL pop_underflow: empty=%0b count=%0d, want 1/0", ptrFifoEmpty, fqCount);
        end
    endtask

    task automatic test_pop_empty_push();
        $display("[TB] test_pop_empty_push");
        ptrDin = 16'hABCD; fqWr = 1'b1; fqRd = 1'b1;
        tick();
        fqWr = 1'b0; fqRd = 1'b0;
        checks++;
        if (fqCount !== 10'd1 || ptrFifoEmpty !== 1'b0 || ptrDoutS !== 10'h3CD) begin
            errors++;
            $display("[TB] FAIL empty_pushpop: count=%0d empty=%0b dout=%0h, want 1/0/3cd",
                     fqCount, ptrFifoEmpty, ptrDoutS);
        end
        fqRd = 1'b1;
        tick();
        fqRd = 1'b0;
        checks++;
        if (fqCount !== 10'd0 || ptrFifoEmpty !== 1'b1) begin
            errors++;
            $display("[TB] FAIL empty_drain: count=%0d empty=%0b, want 0/1", fqCount, ptrFifoEmpty);
        end
    endtask

    task automatic test_mid_init_reset();
        int actEarly;
        $display("[TB] test_mid_init_reset");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int n = 1; n <= 200; n++) tick();
        checks++;
        if (fqCount !== 10'd200 || fqAct !== 1'b0) begin
            errors++;
            $display("[TB] FAIL init200: count=%0d act=%0b, want 200/0", fqCount, fqAct);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (fqCount !== 10'd0 || ptrFifoEmpty !== 1'b1 || fqAct !== 1'b0 || ptrDoutS !== 10'd0) begin
            errors++;
            $display("[TB] FAIL midinit_reset: count=%0d empty=%0b act=%0b dout=%0d, want 0/1/0/0",
                     fqCount, ptrFifoEmpty, fqAct, ptrDoutS);
        end
        rst = 1'b0;
        actEarly = 0;
        for (int n = 1; n <= 511; n++) begin
            tick();
            if (fqAct !== 1'b0) actEarly++;
        end
        tick();
        checks++;
        if (actEarly != 0 || fqAct !== 1'b1 || fqCount !== 10'd512) begin
            errors++;
            $display("[TB] FAIL reinit_act: early=%0d act=%0b count=%0d, want 0/1/512",
                     actEarly, fqAct, fqCount);
        end
    endtask

    task automatic test_back_to_back();
        int headErr;
        $display("[TB] test_back_to_back");
        headErr = 0;
        fqRd = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (ptrDoutS !== 10'(i)) headErr++;
            tick();
        end
        fqRd = 1'b0;
        checks++;
        if (headErr != 0 || ptrDoutS !== 10'd3 || fqCount !== 10'd509) begin
            errors++;
            $display("[TB] FAIL pop3: badHeads=%0d dout=%0d count=%0d, want 0/3/509",
                     headErr, ptrDoutS, fqCount);
        end
        ptrDin = 16'd5; fqRd = 1'b1; fqWr = 1'b1;
        tick();
        fqWr = 1'b0;
        checks++;
        if (fqCount !== 10'd509 || ptrDoutS !== 10'd4) begin
            errors++;
            $display("[TB] FAIL pushpop_mid: count=%0d dout=%0d, want 509/4", fqCount, ptrDoutS);
        end
        for (int i = 0; i < 508; i++) tick();
        fqRd = 1'b0;
        checks++;
        if (ptrDoutS !== 10'd5 || fqCount !== 10'd1) begin
            errors++;
            $display("[TB] FAIL wrap_order: dout=%0d count=%0d, want 5/1", ptrDoutS, fqCount);
        end
    endtask

    task automatic test_traffic_reset();
        $display("[TB] test_traffic_reset");
        rst = 1'b1;
        tick();
        checks++;
        if (fqCount !== 10'd0 || ptrFifoEmpty !== 1'b1 || fqAct !== 1'b0 || ptrDoutS !== 10'd0) begin
            errors++;
            $display("[TB] FAIL traffic_reset: count=%0d empty=%0b act=%0b dout=%0d, want 0/1/0/0",
                     fqCount, ptrFifoEmpty, fqAct, ptrDoutS);
        end
        rst = 1'b0;
        for (int n = 1; n <= 511; n++) tick();
        checks++;
        if (fqAct !== 1'b0) begin
            errors++;
            $display("[TB] FAIL act_511: got %0b want 0", fqAct);
        end
        tick();
        checks++;
        if (fqAct !== 1'b1 || fqCount !== 10'd512 || ptrDoutS !== 10'd0) begin
            errors++;
            $display("[TB] FAIL act_512: act=%0b count=%0d dout=%0d, want 1/512/0", fqAct, fqCount, ptrDoutS);
        end
    endtask

    task automatic test_full_push_pop();
        $display("[TB] test_full_push_pop");
        ptrDin = 16'hFD23; fqRd = 1'b1; fqWr = 1'b1;
        tick();
        fqWr = 1'b0;
        checks++;
        if (fqCount !== 10'd512 || ptrDoutS !== 10'd1) begin
            errors++;
            $display("[TB] FAIL full_pushpop: count=%0d dout=%0d, want 512/1", fqCount, ptrDoutS);
        end
        for (int i = 0; i < 511; i++) tick();
        fqRd = 1'b0;
        checks++;
        if (ptrDoutS !== 10'h123 || fqCount !== 10'd1) begin
            errors++;
            $display("[TB] FAIL full_wrap: dout=%0h count=%0d, want 123/1", ptrDoutS, fqCount);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1; fqWr = 1'b0; fqRd = 1'b0; ptrDin = '0;
        #1;
        test_reset();
        test_push_full();
        test_pop_all();
        test_pop_empty_push();
        test_mid_init_reset();
        test_back_to_back();
        test_traffic_reset();
        test_full_push_pop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_multi_user_free_queue

// File: doc/multi_user_free_queue.md
Name: multi_user_free_queue

Overview:
Free-pointer queue for the shared-memory switch core. It holds the indices of unused 4-line cells in the packet data SRAM.
- After reset it self-initialises with every cell pointer.
- The write path pops one pointer per allocated cell.
- The read path pushes a pointer back when a cell's multicast reference count reaches zero.
- It exposes a show-ahead head pointer, an empty flag, an occupancy count and an initialisation-done flag.

Parameters:
DEPTH, 512, number of cell pointers managed; also the queue capacity.
PTR_W, 10, width of a stored pointer.
CNT_W, 10, width of FQ_count; must hold the value DEPTH.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
ptr_din  input  16  returned pointer; only bits [PTR_W-1:0] are used, bits [15:PTR_W] are ignored
FQ_wr  input  1  push ptr_din[9:0] at the tail
FQ_rd  input  1  pop the head entry
ptr_dout_s  output  10  current head pointer (show-ahead)
ptr_fifo_empty  output  1  queue holds no pointers
FQ_act  output  1  initialisation complete; the queue is usable
FQ_count  output  10  number of pointers currently stored

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values while rst=1: head index=0, tail index=0, FQ_count=0, ptr_fifo_empty=1, FQ_act=0, ptr_dout_s=0, init counter=0.
- Storage: DEPTH x PTR_W array, circular, with head (read) index and tail (write) index. Index arithmetic is modulo DEPTH.
- States: INIT and RUN.
- INIT is entered on the first cycle after rst deasserts.
  - Each cycle, the value k is written into entry k, for k = 0..DEPTH-1.
  - Tail index and FQ_count increment by 1 per cycle.
  - FQ_wr and FQ_rd are ignored during INIT.
- When entry DEPTH-1 has been written, the block moves to RUN.
  - FQ_count is then DEPTH and the tail index has wrapped to 0.
  - FQ_act goes high exactly DEPTH cycles after rst deasserts, and stays high until the next reset.
- RUN, pop: FQ_rd=1 and count>0 → head index +1, count -1.
- RUN, push: FQ_wr=1 and count<DEPTH → entry[tail]=ptr_din[9:0], tail index +1, count +1.
- RUN, push and pop together with 0<count<DEPTH: both take effect; count is unchanged.
- RUN, pop and push together with count=DEPTH: both take effect; count stays DEPTH.
- Pop when empty: ignored; head index does not move, count stays 0. A push in the same cycle still takes effect, giving count 1.
- Push when full: ignored, unless a pop happens in the same cycle.
- ptr_dout_s = entry[head] read combinationally (show-ahead).
  - The consumer samples ptr_dout_s in the same cycle it asserts FQ_rd.
  - ptr_dout_s shows the next entry from the cycle after the pop.
  - ptr_dout_s is forced to 0 while ptr_fifo_empty=1.
- ptr_fifo_empty = (FQ_count==0). It is combinational from the count register.
- FQ_count is registered and updates on the clock edge after the push/pop.
- Ordering is strict FIFO. Returned pointers are reissued only after all earlier-queued pointers.
- No duplicate or validity checking on pushed pointers; the caller guarantees each pointer is returned at most once.
- Reset mid-operation (including mid-INIT) discards all contents and restarts INIT from k=0.

Decomposition:
- Shared package: FQ_DEPTH=512, FQ_PTR_W=10, FQ_CNT_W=10; state encoding INIT/RUN.
- One sub-module: fq_ptr_ram, a DEPTH x PTR_W array with one synchronous write port and one asynchronous read port.
- The top level holds the indices, count, state machine and the mux that selects the init write against the user write.

Test Plan:
1. Pulse rst, then idle → FQ_act=0 for cycles 1..511 after deassert and 1 at cycle 512. FQ_count=512, ptr_fifo_empty=0, ptr_dout_s=0.
2. After init, FQ_rd for 3 cycles → sampled heads 0,1,2. Then ptr_dout_s=3, FQ_count=509.
3. Push ptr_din=16'hFC07 while FQ_count=512 → ignored: count stays 512 and ptr_dout_s is unchanged.
4. Pop all 512 → last head 511, then ptr_fifo_empty=1, FQ_count=0, ptr_dout_s=0. Extra FQ_rd pulses leave count at 0 and empty at 1.
5. Start at count 509 with head=3. Assert FQ_rd and FQ_wr (ptr_din=5) together → FQ_count stays 509, ptr_dout_s becomes 4. After 508 further pops, ptr_dout_s=5 (wrap-around order).
6. Assert rst at cycle 200 of INIT, or mid-traffic → all outputs return to reset values, INIT restarts, and FQ_act rises 512 cycles after the new deassert.
